ibex_rf_wb_buffer: RTL and testbench
====================================

Name: ibex_rf_wb_buffer

Overview:
Write-back merge stage directly upstream of the flip-flop register file's single write port (waddr/wdata/we).
- Merges two write sources:
  - EX/ALU results, which always have priority and never stall.
  - LSU load results, which are queued in a small FIFO when they collide with an EX write.
- Gives read-port forwarding from queued entries, so ID reads (operands a, b and rd) never see stale data.

Parameters:
DataWidth, 32, width of write data and forwarded data.
Depth, 2, number of LSU queue entries; legal range 1..4.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-high reset
ex_we_i  input  1  EX write request, accepted unconditionally
ex_waddr_i  input  5  EX destination register
ex_wdata_i  input  DataWidth  EX write data
lsu_valid_i  input  1  LSU write request
lsu_ready_o  output  1  LSU request accepted when high together with valid
lsu_waddr_i  input  5  LSU destination register
lsu_wdata_i  input  DataWidth  LSU write data
rf_we_o  output  1  register file write enable
rf_waddr_o  output  5  register file write address
rf_wdata_o  output  DataWidth  register file write data
raddr_a_i / raddr_b_i / raddr_rd_i  input  5 each  ID read addresses, snooped
fwd_a_o / fwd_b_o / fwd_rd_o  output  1 each  queued entry matches the address
fwd_a_data_o / fwd_b_data_o / fwd_rd_data_o  output  DataWidth each  forwarded data
pending_o  output  1  queue holds at least one entry

Behaviour:
Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.

Reset and mid-operation reset:
- All queue entries are cleared to invalid and the pointers/count go to 0.
- Asserting reset mid-operation discards queued writes; they are never written.
- While reset is asserted:
  - rf_we_o=0, pending_o=0, fwd_*_o=0.
  - lsu_ready_o=1 (Depth≥1).
  - rf_waddr_o=0 and all data outputs are 0.

Queue structure:
- Circular FIFO of {valid, waddr, wdata}.
- Head/tail pointers wrap modulo Depth.
- Count runs 0..Depth.

lsu_ready_o:
- lsu_ready_o = (count != Depth). It does not depend on a same-cycle pop.
- Handshake: an LSU beat is transferred when lsu_valid_i & lsu_ready_o.
- While lsu_ready_o=0, data must be held stable.

Write port selection, evaluated combinationally each cycle in priority order:
1. ex_we_i=1:
   - rf_* takes the EX fields; rf_we_o=1 only if ex_waddr_i!=0.
2. Otherwise, head entry valid:
   - rf_* takes the head fields; the head is popped.
3. Otherwise, head entry invalid and count>0:
   - Head is popped with rf_we_o=0.
   - An invalid head pops in every cycle, including cycles with an EX write.
4. Otherwise: bypass (see Optional Feature), else rf_we_o=0.

Kill rule (ordering):
- An LSU result is always older than a same-cycle EX result.
- When ex_we_i=1, every queued entry with waddr==ex_waddr_i is marked invalid in that cycle.
- An LSU beat accepted in the same cycle with the same waddr is enqueued invalid.
- LSU beats with waddr==0 are accepted and enqueued invalid.

Simultaneous push and pop: both are allowed in one cycle; count is unchanged.

Forwarding:
- fwd_x_o=1 when a valid queued entry has waddr==raddr_x_i and raddr_x_i!=0.
- On multiple matches, data comes from the youngest matching entry.
- Purely combinational from register state. It does not consider same-cycle inputs.

pending_o = (count != 0).

Latency:
- EX write: 0 cycles (same cycle on rf_*).
- Queued LSU write: at least 1 cycle after acceptance, and only in a cycle with ex_we_i=0.

Optional Feature:
Macro: IBEX_WB_BUF_BYPASS_EN
- Defined:
  - Condition: lsu_valid_i=1, ex_we_i=0 and count==0.
  - Effect: the beat is accepted and written on rf_* in the same cycle, not enqueued; rf_we_o=1 iff lsu_waddr_i!=0.
- Not defined:
  - Every accepted LSU beat is enqueued.
  - The earliest register file write is the next cycle.

Test Plan:
1. Reset, then ex_we_i=1, ex_waddr_i=5, ex_wdata_i=0xDEADBEEF -> same cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; pending_o stays 0.
2. LSU waddr=7, data=0x11 with ex_we_i=1 on waddr=3 for 2 cycles:
   - LSU is enqueued and fwd_a_o=1 for raddr_a_i=7 with fwd_a_data_o=0x11.
   - In the first ex_we_i=0 cycle, rf_waddr_o=7 and rf_wdata_o=0x11; then pending_o=0.
3. Depth=2; fill with LSU waddr 8 then waddr 8 (data 0xA, then 0xB) while EX is busy:
   - lsu_ready_o=0 and fwd_b_data_o=0xB for raddr_b_i=8.
   - Drains: writes 0xA, then 0xB.
4. Queue holds waddr=9 data=0x22; EX writes waddr=9 data=0x33:
   - rf writes 0x33, the entry is killed, and fwd for address 9 drops to 0.
   - The next pop has rf_we_o=0, and register 9 ends at 0x33.
5. LSU waddr=0 accepted -> no rf_we_o ever for it; pending_o drops after one pop cycle.
6. Assert rst_i while 2 entries are queued -> outputs go immediately to reset values; after release no queued write appears.
   - Repeat with IBEX_WB_BUF_BYPASS_EN defined: LSU waddr=4 with an empty queue and EX idle -> rf_we_o=1 in the same cycle.

Source files
------------

// File: rtl/ibex_rf_wb_buffer.sv
// Merges EX results (0-cycle, never stalled) and queued LSU results onto the RF write port, forwarding queued data to ID reads.
// lsu_ready_o drops only when the queue is full; IBEX_WB_BUF_BYPASS_EN lets an LSU beat write straight through when EX is idle and the queue is empty.
module ibex_rf_wb_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,

  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,

  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,

  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           raddr_rd_i,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic                 fwd_rd_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic [DataWidth-1:0] fwd_rd_data_o,

  output logic                 pending_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic                 valid;
    logic [4:0]           waddr;
    logic [DataWidth-1:0] wdata;
  } entry_t;

  entry_t          q [Depth];
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [CntW-1:0] count;

  entry_t head_e;
  entry_t push_e;
  logic   full;
  logic   empty;
  logic   pop;
  logic   push;
  logic   bypass;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head_e      = q[head];
  assign full        = (count == CntW'(Depth));
  assign empty       = (count == '0);
  assign lsu_ready_o = ~full;
  assign pending_o   = ~empty;

  // A killed (invalid) head drains even while EX owns the write port.
  assign pop = ~empty & (~ex_we_i | ~head_e.valid);

`ifdef IBEX_WB_BUF_BYPASS_EN
  assign bypass = lsu_valid_i & ~ex_we_i & empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = lsu_valid_i & ~full & ~bypass;

  // The LSU result is older than a same-cycle EX write to the same register.
  assign push_e.valid = (lsu_waddr_i != 5'd0) &
                        ~(ex_we_i & (ex_waddr_i == lsu_waddr_i));
  assign push_e.waddr = lsu_waddr_i;
  assign push_e.wdata = lsu_wdata_i;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (!rst_i) begin
      if (ex_we_i) begin
        rf_we_o    = (ex_waddr_i != 5'd0);
        rf_waddr_o = ex_waddr_i;
        rf_wdata_o = ex_wdata_i;
      end else if (!empty && head_e.valid) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = head_e.waddr;
        rf_wdata_o = head_e.wdata;
      end else if (bypass) begin
        rf_we_o    = (lsu_waddr_i != 5'd0);
        rf_waddr_o = lsu_waddr_i;
        rf_wdata_o = lsu_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        q[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (ex_we_i && (q[i].waddr == ex_waddr_i)) begin
          q[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        q[head].valid <= 1'b0;
        head          <= ptr_inc(head);
      end
      if (push) begin
        q[tail] <= push_e;
        tail    <= ptr_inc(tail);
      end
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // Forwarding walks entries oldest to youngest so the youngest match wins.
  logic [4:0]           raddr   [3];
  logic [2:0]           fwd_hit;
  logic [DataWidth-1:0] fwd_dat [3];
  logic [PtrW:0]        age_sum;
  logic [PtrW-1:0]      age_idx;

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;
  assign raddr[2] = raddr_rd_i;

  always_comb begin
    fwd_hit = '0;
    age_sum = '0;
    age_idx = '0;
    for (int p = 0; p < 3; p++) begin
      fwd_dat[p] = '0;
      for (int k = 0; k < int'(Depth); k++) begin
        age_sum = {1'b0, head} + (PtrW + 1)'(k);
        if (age_sum >= (PtrW + 1)'(Depth)) begin
          age_sum = age_sum - (PtrW + 1)'(Depth);
        end
        age_idx = age_sum[PtrW-1:0];
        if ((CntW'(k) < count) && q[age_idx].valid &&
            (q[age_idx].waddr == raddr[p]) && (raddr[p] != 5'd0)) begin
          fwd_hit[p] = 1'b1;
          fwd_dat[p] = q[age_idx].wdata;
        end
      end
    end
  end

  assign fwd_a_o       = fwd_hit[0];
  assign fwd_b_o       = fwd_hit[1];
  assign fwd_rd_o      = fwd_hit[2];
  assign fwd_a_data_o  = fwd_dat[0];
  assign fwd_b_data_o  = fwd_dat[1];
  assign fwd_rd_data_o = fwd_dat[2];

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// Directed bench for ibex_rf_wb_buffer: hand-computed expectations per cycle, default Depth=2.
module tb_ibex_rf_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  raddr_a_i, raddr_b_i, raddr_rd_i;
  logic        fwd_a_o, fwd_b_o, fwd_rd_o;
  logic [31:0] fwd_a_data_o, fwd_b_data_o, fwd_rd_data_o;
  logic        pending_o;

  int n_vec = 0;
  int n_err = 0;

  ibex_rf_wb_buffer #(.DataWidth(32), .Depth(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ex_we_i       (ex_we_i),
    .ex_waddr_i    (ex_waddr_i),
    .ex_wdata_i    (ex_wdata_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_waddr_i   (lsu_waddr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .raddr_rd_i    (raddr_rd_i),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .fwd_rd_o      (fwd_rd_o),
    .fwd_a_data_o  (fwd_a_data_o),
    .fwd_b_data_o  (fwd_b_data_o),
    .fwd_rd_data_o (fwd_rd_data_o),
    .pending_o     (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc_end();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic idle();
    ex_we_i     = 1'b0;
    ex_waddr_i  = '0;
    ex_wdata_i  = '0;
    lsu_valid_i = 1'b0;
    lsu_waddr_i = '0;
    lsu_wdata_i = '0;
    raddr_a_i   = '0;
    raddr_b_i   = '0;
    raddr_rd_i  = '0;
  endtask

  task automatic ex(input logic [4:0] a, input logic [31:0] d);
    ex_we_i    = 1'b1;
    ex_waddr_i = a;
    ex_wdata_i = d;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_valid_i = 1'b1;
    lsu_waddr_i = a;
    lsu_wdata_i = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    // Reset with EX driving a write: outputs must still be quiet.
    idle();
    rst_i = 1'b1;
    ex(5'd5, 32'hFFFF_FFFF);
    mid();
    chk("rst_we",      32'(rf_we_o),     32'd0);
    chk("rst_waddr",   32'(rf_waddr_o),  32'd0);
    chk("rst_wdata",   rf_wdata_o,       32'd0);
    chk("rst_pending", 32'(pending_o),   32'd0);
    chk("rst_ready",   32'(lsu_ready_o), 32'd1);
    chk("rst_fwd_a",   32'(fwd_a_o),     32'd0);
    cyc_end();
    rst_i = 1'b0;

    // EX write lands in the same cycle.
    idle();
    ex(5'd5, 32'hDEAD_BEEF);
    mid();
    chk("ex_we",    32'(rf_we_o),    32'd1);
    chk("ex_waddr", 32'(rf_waddr_o), 32'd5);
    chk("ex_wdata", rf_wdata_o,      32'hDEAD_BEEF);
    cyc_end();
    chk("ex_pending", 32'(pending_o), 32'd0);

    // EX to x0 is not written.
    ex(5'd0, 32'h1234);
    mid();
    chk("ex_x0_we", 32'(rf_we_o), 32'd0);
    cyc_end();

    // LSU collides with EX for two cycles, then drains.
    idle();
    ex(5'd3, 32'h100);
    lsu(5'd7, 32'h11);
    mid();
    chk("col_ex_waddr", 32'(rf_waddr_o), 32'd3);
    cyc_end();
    idle();
    ex(5'd3, 32'h101);
    raddr_a_i = 5'd7;
    mid();
    chk("col_fwd_a",     32'(fwd_a_o),    32'd1);
    chk("col_fwd_a_dat", fwd_a_data_o,    32'h11);
    chk("col_pending",   32'(pending_o),  32'd1);
    chk("col_ex_wdata",  rf_wdata_o,      32'h101);
    cyc_end();
    ex_we_i = 1'b0;
    mid();
    chk("col_drain_we",    32'(rf_we_o),    32'd1);
    chk("col_drain_waddr", 32'(rf_waddr_o), 32'd7);
    chk("col_drain_wdata", rf_wdata_o,      32'h11);
    cyc_end();
    chk("col_empty",   32'(pending_o), 32'd0);
    chk("col_fwd_off", 32'(fwd_a_o),   32'd0);

    // Fill to full with two writes to x8, youngest forwards; stalled beat waits.
    idle();
    ex(5'd1, 32'h0);
    lsu(5'd8, 32'hA);
    cyc_end();
    lsu(5'd8, 32'hB);
    mid();
    chk("fill_ready1", 32'(lsu_ready_o), 32'd1);
    cyc_end();
    lsu(5'd12, 32'hC);
    raddr_b_i = 5'd8;
    mid();
    chk("full_ready",   32'(lsu_ready_o), 32'd0);
    chk("full_fwd_b",   32'(fwd_b_o),     32'd1);
    chk("full_fwd_dat", fwd_b_data_o,     32'hB);
    cyc_end();
    ex_we_i = 1'b0;
    mid();
    chk("drain1_waddr", 32'(rf_waddr_o),  32'd8);
    chk("drain1_wdata", rf_wdata_o,       32'hA);
    chk("drain1_ready", 32'(lsu_ready_o), 32'd0);
    cyc_end();
    mid();
    chk("drain2_we",    32'(rf_we_o),     32'd1);
    chk("drain2_wdata", rf_wdata_o,       32'hB);
    chk("drain2_ready", 32'(lsu_ready_o), 32'd1);
    cyc_end();
    lsu_valid_i = 1'b0;
    mid();
    chk("drain3_waddr", 32'(rf_waddr_o), 32'd12);
    chk("drain3_wdata", rf_wdata_o,      32'hC);
    cyc_end();
    chk("drain_empty", 32'(pending_o), 32'd0);

    // Queued x9 gets killed by a younger EX write to x9.
    idle();
    ex(5'd2, 32'h0);
    lsu(5'd9, 32'h22);
    cyc_end();
    idle();
    ex(5'd9, 32'h33);
    raddr_a_i = 5'd9;
    mid();
    chk("kill_fwd_before", 32'(fwd_a_o),    32'd1);
    chk("kill_fwd_dat",    fwd_a_data_o,    32'h22);
    chk("kill_ex_wdata",   rf_wdata_o,      32'h33);
    cyc_end();
    ex_we_i = 1'b0;
    mid();
    chk("kill_fwd_after", 32'(fwd_a_o),   32'd0);
    chk("kill_pending",   32'(pending_o), 32'd1);
    chk("kill_pop_we",    32'(rf_we_o),   32'd0);
    cyc_end();
    chk("kill_empty", 32'(pending_o), 32'd0);

    // Same-cycle LSU and EX to the same register: LSU beat enqueued dead.
    idle();
    ex(5'd6, 32'h66);
    lsu(5'd6, 32'h44);
    cyc_end();
    idle();
    raddr_rd_i = 5'd6;
    mid();
    chk("same_fwd_rd", 32'(fwd_rd_o),  32'd0);
    chk("same_pend",   32'(pending_o), 32'd1);
    chk("same_we",     32'(rf_we_o),   32'd0);
    cyc_end();
    chk("same_empty", 32'(pending_o), 32'd0);

    // LSU to x0 is accepted but never written.
    idle();
    ex(5'd1, 32'h0);
    lsu(5'd0, 32'h55);
    mid();
    chk("x0_ready", 32'(lsu_ready_o), 32'd1);
    cyc_end();
    idle();
    mid();
    chk("x0_pend", 32'(pending_o), 32'd1);
    chk("x0_we",   32'(rf_we_o),   32'd0);
    cyc_end();
    chk("x0_empty", 32'(pending_o), 32'd0);

    // Reset mid-operation discards two queued writes.
    idle();
    ex(5'd1, 32'h0);
    lsu(5'd10, 32'hAA);
    cyc_end();
    lsu(5'd11, 32'hBB);
    cyc_end();
    idle();
    raddr_a_i = 5'd10;
    #1;
    chk("mrst_pre_fwd", 32'(fwd_a_o),   32'd1);
    chk("mrst_pre_pend", 32'(pending_o), 32'd1);
    rst_i = 1'b1;
    ex(5'd13, 32'h99);
    #1;
    chk("mrst_we",    32'(rf_we_o),     32'd0);
    chk("mrst_waddr", 32'(rf_waddr_o),  32'd0);
    chk("mrst_wdata", rf_wdata_o,       32'd0);
    chk("mrst_pend",  32'(pending_o),   32'd0);
    chk("mrst_ready", 32'(lsu_ready_o), 32'd1);
    chk("mrst_fwd_a", 32'(fwd_a_o),     32'd0);
    cyc_end();
    rst_i = 1'b0;
    idle();
    mid();
    chk("post_rst_we",   32'(rf_we_o),   32'd0);
    chk("post_rst_pend", 32'(pending_o), 32'd0);
    cyc_end();
    mid();
    chk("post_rst_we2", 32'(rf_we_o), 32'd0);
    cyc_end();

    // LSU into an empty queue with EX idle.
    idle();
    lsu(5'd4, 32'h77);
    mid();
`ifdef IBEX_WB_BUF_BYPASS_EN
    chk("byp_we",    32'(rf_we_o),    32'd1);
    chk("byp_waddr", 32'(rf_waddr_o), 32'd4);
    chk("byp_wdata", rf_wdata_o,      32'h77);
`else
    chk("nobyp_we",    32'(rf_we_o),     32'd0);
    chk("nobyp_ready", 32'(lsu_ready_o), 32'd1);
`endif
    cyc_end();
    lsu_valid_i = 1'b0;
    mid();
`ifdef IBEX_WB_BUF_BYPASS_EN
    chk("byp_pend", 32'(pending_o), 32'd0);
    chk("byp_we2",  32'(rf_we_o),   32'd0);
`else
    chk("nobyp_pend",  32'(pending_o),  32'd1);
    chk("nobyp_waddr", 32'(rf_waddr_o), 32'd4);
    chk("nobyp_wdata", rf_wdata_o,      32'h77);
`endif
    cyc_end();
    chk("byp_empty", 32'(pending_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
